// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_mem_arbiter                                                          |
// | Round-robin CPU/video read arbiter with CPU write priority onto a        |
// | pipelined single-port synchronous RAM.                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_mem_arbiter #(
  parameter int RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd_req,
  output logic        cpu_rd_ack,
  output logic [7:0]  cpu_rd_data,
  input  logic        cpu_wr_enable,
  input  logic [7:0]  cpu_wr_data,
  input  logic [15:0] vid_addr,
  input  logic        vid_rd_req,
  output logic        vid_rd_ack,
  output logic [7:0]  vid_rd_data,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wr_data,
  input  logic [7:0]  ram_rd_data
);

  localparam logic c_TAG_CPU = 1'b0;
  localparam logic c_TAG_VID = 1'b1;

  logic                   r_cpu_busy;
  logic                   r_vid_busy;
  logic                   r_last_vid;
  logic [RAM_LATENCY-1:0] r_pipe_vld;
  logic [RAM_LATENCY-1:0] r_pipe_tag;

  logic w_cpu_elig;
  logic w_vid_elig;
  logic w_tie;
  logic w_issue_cpu;
  logic w_issue_vid;
  logic w_ret_cpu;
  logic w_ret_vid;

  // The ack cycle still shows the master's stale request, so it is masked.
  assign w_cpu_elig = cpu_rd_req & ~r_cpu_busy & ~cpu_rd_ack;
  assign w_vid_elig = vid_rd_req & ~r_vid_busy & ~vid_rd_ack;
  assign w_tie      = w_cpu_elig & w_vid_elig & ~cpu_wr_enable;

  always_comb begin
    w_issue_cpu = 1'b0;
    w_issue_vid = 1'b0;
    if (!cpu_wr_enable) begin
      if (w_cpu_elig && w_vid_elig) begin
        w_issue_cpu = r_last_vid;
        w_issue_vid = ~r_last_vid;
      end else begin
        w_issue_cpu = w_cpu_elig;
        w_issue_vid = w_vid_elig;
      end
    end
  end

  assign w_ret_cpu = r_pipe_vld[RAM_LATENCY-1] & (r_pipe_tag[RAM_LATENCY-1] == c_TAG_CPU);
  assign w_ret_vid = r_pipe_vld[RAM_LATENCY-1] & (r_pipe_tag[RAM_LATENCY-1] == c_TAG_VID);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_rd_ack  <= 1'b0;
      cpu_rd_data <= 8'h00;
      vid_rd_ack  <= 1'b0;
      vid_rd_data <= 8'h00;
      ram_addr    <= 16'h0000;
      ram_we      <= 1'b0;
      ram_wr_data <= 8'h00;
      r_cpu_busy  <= 1'b0;
      r_vid_busy  <= 1'b0;
      r_last_vid  <= 1'b0;
      r_pipe_vld  <= '0;
      r_pipe_tag  <= '0;
    end else begin
      ram_we <= cpu_wr_enable;
      if (cpu_wr_enable) begin
        ram_addr    <= cpu_addr;
        ram_wr_data <= cpu_wr_data;
      end else if (w_issue_cpu) begin
        ram_addr <= cpu_addr;
      end else if (w_issue_vid) begin
        ram_addr <= vid_addr;
      end

      // Fairness history only moves when a real tie was resolved.
      if (w_tie) begin
        r_last_vid <= w_issue_vid;
      end

      r_pipe_vld[0] <= w_issue_cpu | w_issue_vid;
      r_pipe_tag[0] <= w_issue_vid ? c_TAG_VID : c_TAG_CPU;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end

      cpu_rd_ack <= w_ret_cpu;
      vid_rd_ack <= w_ret_vid;
      if (w_ret_cpu) begin
        cpu_rd_data <= ram_rd_data;
      end
      if (w_ret_vid) begin
        vid_rd_data <= ram_rd_data;
      end

      if (w_issue_cpu) begin
        r_cpu_busy <= 1'b1;
      end else if (w_ret_cpu) begin
        r_cpu_busy <= 1'b0;
      end
      if (w_issue_vid) begin
        r_vid_busy <= 1'b1;
      end else if (w_ret_vid) begin
        r_vid_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_mem_arbiter                                                       |
// | Bench for cpu_mem_arbiter at RAM_LATENCY 1 (dut0) and 3 (dut1).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cpu_mem_arbiter;

  logic        clk;
  logic        reset_n       [2];
  logic [15:0] cpu_addr      [2];
  logic        cpu_rd_req    [2];
  logic        cpu_rd_ack    [2];
  logic [7:0]  cpu_rd_data   [2];
  logic        cpu_wr_enable [2];
  logic [7:0]  cpu_wr_data   [2];
  logic [15:0] vid_addr      [2];
  logic        vid_rd_req    [2];
  logic        vid_rd_ack    [2];
  logic [7:0]  vid_rd_data   [2];
  logic [15:0] ram_addr      [2];
  logic        ram_we        [2];
  logic [7:0]  ram_wr_data   [2];
  logic [7:0]  ram_rd_data   [2];

  logic [7:0]  mem  [2][65536];
  logic [7:0]  mmem [2][65536];
  logic [15:0] addr_d1;
  logic [15:0] addr_d2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int cpu_ack_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    cpu_mem_arbiter #(.RAM_LATENCY(k == 0 ? 1 : 3)) u_dut (
      .clk           (clk),
      .reset_n       (reset_n[k]),
      .cpu_addr      (cpu_addr[k]),
      .cpu_rd_req    (cpu_rd_req[k]),
      .cpu_rd_ack    (cpu_rd_ack[k]),
      .cpu_rd_data   (cpu_rd_data[k]),
      .cpu_wr_enable (cpu_wr_enable[k]),
      .cpu_wr_data   (cpu_wr_data[k]),
      .vid_addr      (vid_addr[k]),
      .vid_rd_req    (vid_rd_req[k]),
      .vid_rd_ack    (vid_rd_ack[k]),
      .vid_rd_data   (vid_rd_data[k]),
      .ram_addr      (ram_addr[k]),
      .ram_we        (ram_we[k]),
      .ram_wr_data   (ram_wr_data[k]),
      .ram_rd_data   (ram_rd_data[k])
    );
  end

  // RAM: data for the address shown in cycle A is readable in cycle A+LAT-1.
  assign ram_rd_data[0] = mem[0][ram_addr[0]];
  assign ram_rd_data[1] = mem[1][addr_d2];
  always @(posedge clk) begin
    addr_d1 <= ram_addr[1];
    addr_d2 <= addr_d1;
    for (int k = 0; k < 2; k++)
      if (ram_we[k] === 1'b1) mem[k][ram_addr[k]] <= ram_wr_data[k];
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", name, k, cyc, act, exp);
    end
  endtask

  // Model: each master's read is described by the cycle its ack is due.
  int          due     [2][2];
  logic [7:0]  dval    [2][2];
  logic [7:0]  exp_dat [2][2];
  logic        exp_we  [2];
  logic [15:0] exp_ra  [2];
  logic [7:0]  exp_wd  [2];
  logic        vid_won [2];
  bit          mvalid  [2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int lat = (k == 0) ? 1 : 3;
      automatic bit ec, ev;
      if (mvalid[k]) begin
        for (int m = 0; m < 2; m++)
          if (due[k][m] == cyc) exp_dat[k][m] = dval[k][m];
        chk("cpu_rd_ack",  k, 32'(cpu_rd_ack[k]),  32'(due[k][0] == cyc));
        chk("vid_rd_ack",  k, 32'(vid_rd_ack[k]),  32'(due[k][1] == cyc));
        chk("cpu_rd_data", k, 32'(cpu_rd_data[k]), 32'(exp_dat[k][0]));
        chk("vid_rd_data", k, 32'(vid_rd_data[k]), 32'(exp_dat[k][1]));
        chk("ram_we",      k, 32'(ram_we[k]),      32'(exp_we[k]));
        chk("ram_addr",    k, 32'(ram_addr[k]),    32'(exp_ra[k]));
        chk("ram_wr_data", k, 32'(ram_wr_data[k]), 32'(exp_wd[k]));
        if (k == 0 && cpu_rd_ack[k] === 1'b1) cpu_ack_cnt++;
      end
      if (!reset_n[k]) begin
        mvalid[k] = 1;
        for (int m = 0; m < 2; m++) begin
          due[k][m] = -1;
          exp_dat[k][m] = 8'h00;
        end
        exp_we[k] = 0; exp_ra[k] = 16'h0; exp_wd[k] = 8'h0; vid_won[k] = 0;
      end else if (mvalid[k]) begin
        ec = cpu_rd_req[k] && due[k][0] < cyc;
        ev = vid_rd_req[k] && due[k][1] < cyc;
        exp_we[k] = cpu_wr_enable[k];
        if (cpu_wr_enable[k]) begin
          exp_ra[k] = cpu_addr[k];
          exp_wd[k] = cpu_wr_data[k];
          mmem[k][cpu_addr[k]] = cpu_wr_data[k];
        end else begin
          if (ec && ev) begin
            ec = vid_won[k];
            ev = !vid_won[k];
            vid_won[k] = ev;
          end
          if (ec) begin
            due[k][0] = cyc + 1 + lat;
            dval[k][0] = mmem[k][cpu_addr[k]];
            exp_ra[k] = cpu_addr[k];
          end else if (ev) begin
            due[k][1] = cyc + 1 + lat;
            dval[k][1] = mmem[k][vid_addr[k]];
            exp_ra[k] = vid_addr[k];
          end
        end
      end
    end
  end

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    at_cycle(c);
    @(negedge clk);
  endtask

  task automatic poke(input int k, input logic [15:0] a, input logic [7:0] v);
    mem[k][a] = v;
    mmem[k][a] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int snap;
    for (int k = 0; k < 2; k++) begin
      reset_n[k] = 0; cpu_addr[k] = 0; cpu_rd_req[k] = 0; cpu_wr_enable[k] = 0;
      cpu_wr_data[k] = 0; vid_addr[k] = 0; vid_rd_req[k] = 0;
    end
    poke(0, 16'h0444, 8'hA9); poke(0, 16'h1000, 8'h34); poke(0, 16'h1001, 8'h12);
    poke(0, 16'h0010, 8'h11); poke(0, 16'h8000, 8'h80); poke(0, 16'h0020, 8'h22);
    poke(0, 16'h8001, 8'h81); poke(0, 16'h8002, 8'h82);
    poke(1, 16'h0300, 8'h33); poke(1, 16'h0100, 8'h44); poke(1, 16'h0200, 8'h55);
    at_cycle(3);
    reset_n[0] = 1; reset_n[1] = 1;
    at_neg(4);
    chk("reset_ram_addr", 0, 32'(ram_addr[0]), 32'h0);
    chk("reset_cpu_data", 1, 32'(cpu_rd_data[1]), 32'h0);

    // Single CPU read
    t0 = 6; at_cycle(t0);
    cpu_addr[0] = 16'h0444; cpu_rd_req[0] = 1;
    at_neg(t0 + 1); chk("single_ram_addr", 0, 32'(ram_addr[0]), 32'h0444);
                    chk("single_no_early_ack", 0, 32'(cpu_rd_ack[0]), 32'h0);
    at_neg(t0 + 2); chk("single_ack", 0, 32'(cpu_rd_ack[0]), 32'h1);
                    chk("single_data", 0, 32'(cpu_rd_data[0]), 32'hA9);
    at_cycle(t0 + 3); cpu_rd_req[0] = 0;
    at_neg(t0 + 3); chk("single_ack_drop", 0, 32'(cpu_rd_ack[0]), 32'h0);
                    chk("single_data_held", 0, 32'(cpu_rd_data[0]), 32'hA9);

    // CPU word read
    t0 = 14; at_neg(t0); snap = cpu_ack_cnt;
    at_cycle(t0 + 1); t0 = t0 + 1;
    cpu_addr[0] = 16'h1000; cpu_rd_req[0] = 1;
    at_neg(t0 + 2); chk("word_ack1_data", 0, 32'(cpu_rd_data[0]), 32'h34);
    at_cycle(t0 + 3); cpu_addr[0] = 16'h1001;
    at_neg(t0 + 5); chk("word_ack2", 0, 32'(cpu_rd_ack[0]), 32'h1);
                    chk("word_ack2_data", 0, 32'(cpu_rd_data[0]), 32'h12);
    at_cycle(t0 + 6); cpu_rd_req[0] = 0;
    at_neg(t0 + 9); chk("word_ack_count", 0, 32'(cpu_ack_cnt - snap), 32'd2);

    // Simultaneous requests after reset
    t0 = 30; at_cycle(t0); reset_n[0] = 0;
    at_cycle(t0 + 2); reset_n[0] = 1;
    t0 = t0 + 2;
    cpu_addr[0] = 16'h0010; vid_addr[0] = 16'h8000; cpu_rd_req[0] = 1; vid_rd_req[0] = 1;
    at_neg(t0 + 1); chk("tie1_ram_addr", 0, 32'(ram_addr[0]), 32'h8000);
    at_neg(t0 + 2); chk("tie1_vid_ack", 0, 32'(vid_rd_ack[0]), 32'h1);
                    chk("tie1_vid_data", 0, 32'(vid_rd_data[0]), 32'h80);
    at_cycle(t0 + 3); vid_rd_req[0] = 0;
    at_neg(t0 + 3); chk("tie1_cpu_ack", 0, 32'(cpu_rd_ack[0]), 32'h1);
                    chk("tie1_cpu_data", 0, 32'(cpu_rd_data[0]), 32'h11);
    at_cycle(t0 + 4); cpu_rd_req[0] = 0;
    at_cycle(t0 + 6);
    cpu_addr[0] = 16'h0020; vid_addr[0] = 16'h8001; cpu_rd_req[0] = 1; vid_rd_req[0] = 1;
    at_neg(t0 + 8); chk("tie2_cpu_ack", 0, 32'(cpu_rd_ack[0]), 32'h1);
                    chk("tie2_cpu_data", 0, 32'(cpu_rd_data[0]), 32'h22);
    at_cycle(t0 + 9); cpu_rd_req[0] = 0;
    at_neg(t0 + 9); chk("tie2_vid_ack", 0, 32'(vid_rd_ack[0]), 32'h1);
                    chk("tie2_vid_data", 0, 32'(vid_rd_data[0]), 32'h81);
    at_cycle(t0 + 10); vid_rd_req[0] = 0;

    // Write preemption, then read the written byte back
    t0 = 50; at_cycle(t0);
    cpu_wr_enable[0] = 1; cpu_addr[0] = 16'h2000; cpu_wr_data[0] = 8'h5A;
    vid_addr[0] = 16'h8002; vid_rd_req[0] = 1;
    at_cycle(t0 + 1); cpu_wr_enable[0] = 0;
    at_neg(t0 + 1); chk("wr_we", 0, 32'(ram_we[0]), 32'h1);
                    chk("wr_addr", 0, 32'(ram_addr[0]), 32'h2000);
                    chk("wr_data", 0, 32'(ram_wr_data[0]), 32'h5A);
    at_neg(t0 + 2); chk("wr_vid_not_yet", 0, 32'(vid_rd_ack[0]), 32'h0);
    at_neg(t0 + 3); chk("wr_vid_ack", 0, 32'(vid_rd_ack[0]), 32'h1);
                    chk("wr_vid_data", 0, 32'(vid_rd_data[0]), 32'h82);
    at_cycle(t0 + 4); vid_rd_req[0] = 0;
    at_cycle(t0 + 5); cpu_rd_req[0] = 1;
    at_neg(t0 + 7); chk("wr_readback", 0, 32'(cpu_rd_data[0]), 32'h5A);
    at_cycle(t0 + 8); cpu_rd_req[0] = 0;

    // Reset mid-read
    t0 = 65; at_cycle(t0);
    cpu_addr[0] = 16'h0444; cpu_rd_req[0] = 1;
    at_cycle(t0 + 1); reset_n[0] = 0;
    at_cycle(t0 + 2); reset_n[0] = 1;
    at_neg(t0 + 2); chk("rst_no_ack", 0, 32'(cpu_rd_ack[0]), 32'h0);
                    chk("rst_data_zero", 0, 32'(cpu_rd_data[0]), 32'h0);
                    chk("rst_addr_zero", 0, 32'(ram_addr[0]), 32'h0);
    at_neg(t0 + 4); chk("rst_fresh_ack", 0, 32'(cpu_rd_ack[0]), 32'h1);
                    chk("rst_fresh_data", 0, 32'(cpu_rd_data[0]), 32'hA9);
    at_cycle(t0 + 5); cpu_rd_req[0] = 0;

    // RAM_LATENCY = 3
    t0 = 75; at_cycle(t0);
    vid_addr[1] = 16'h0300; vid_rd_req[1] = 1;
    at_neg(t0 + 3); chk("l3_vid_not_yet", 1, 32'(vid_rd_ack[1]), 32'h0);
    at_neg(t0 + 4); chk("l3_vid_ack", 1, 32'(vid_rd_ack[1]), 32'h1);
                    chk("l3_vid_data", 1, 32'(vid_rd_data[1]), 32'h33);
    at_cycle(t0 + 5); vid_rd_req[1] = 0;
    t0 = 82; at_cycle(t0);
    cpu_addr[1] = 16'h0100; cpu_rd_req[1] = 1;
    at_cycle(t0 + 1); vid_addr[1] = 16'h0200; vid_rd_req[1] = 1;
    at_neg(t0 + 4); chk("l3_cpu_ack", 1, 32'(cpu_rd_ack[1]), 32'h1);
                    chk("l3_cpu_data", 1, 32'(cpu_rd_data[1]), 32'h44);
                    chk("l3_vid_after", 1, 32'(vid_rd_ack[1]), 32'h0);
    at_cycle(t0 + 5); cpu_rd_req[1] = 0;
    at_neg(t0 + 5); chk("l3_vid_ack2", 1, 32'(vid_rd_ack[1]), 32'h1);
                    chk("l3_vid_data2", 1, 32'(vid_rd_data[1]), 32'h55);
    at_cycle(t0 + 6); vid_rd_req[1] = 0;

    at_neg(t0 + 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
